// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
//   N_REQ   : number of requesters sharing the mux
//   idx_t   : requester index / mux select
//   state_t : arbiter FSM state (IDLE, GRANT)
package mux_arb_pkg;

  localparam int N_REQ = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the requesters and the round-robin mux arbiter.
//   req     : per-requester request, held high while requester i wants or uses the mux
//   done    : the current owner ends its transaction this cycle
//   gnt     : registered one-hot grant, zero when idle
//   sel     : registered 4:1 mux select, equals the owner index while granted
//   busy    : high while any grant is active
//   timeout : one-cycle pulse after a forced release
//
// Handshake: req[i] acts as valid and gnt[i] as ready. Requester i owns the
// mux for every cycle in which both are high. Ownership ends at the first edge
// where done is high or req[i] is low, or once the hold limit is reached.
// Requests from non-owners are not accepted while a grant is active.
interface mux4_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  idx_t             sel;
  logic             busy;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, sel, busy, timeout
  );

  modport slave (
    input  req, done,
    output gnt, sel, busy, timeout
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick over four requests.
//   req    : request vector
//   last   : index of the previous winner; the search starts at last+1
//   winner : first set request found from last+1, wrapping 3 -> 0
//   any    : at least one request set (winner is meaningless otherwise)
// The requests are rotated so that index last+1 sits at position 0. A fixed
// priority pick is made on the rotated vector, and the offset is then added back.
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             last,
  output idx_t             winner,
  output logic             any
);

  idx_t             start;
  logic [N_REQ-1:0] rot;
  idx_t             pick;

  always_comb begin
    start = last + 2'd1;
    for (int k = 0; k < N_REQ; k++) begin
      rot[k] = req[idx_t'(start + idx_t'(k))];
    end
    // The descending loop leaves the lowest set rotated position in pick.
    pick = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) pick = idx_t'(k);
    end
    winner = start + pick;
    any    = |req;
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for one shared 4:1 datapath mux.
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset
//   bus      : slave side of mux4_rr_arbiter_if (req/done in, gnt/sel/busy/timeout out)
//   state_o  : current FSM state, for observation
// Parameters:
//   MAX_HOLD : maximum consecutive cycles an owner may hold the mux (2..256)
// All outputs come from flops. Between owners there is always one idle cycle.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int MAX_HOLD = 16,
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic                clk,
  input  logic                rst_n,
  mux4_rr_arbiter_if.slave    bus,
  output state_t              state_o
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  idx_t             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;
  idx_t             last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  idx_t winner;
  logic any_req;
  logic owner_release;
  logic hold_expired;

  rr_priority_pick u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // sel_q is the owner index for the whole time the grant is held.
  assign owner_release = bus.done || !bus.req[sel_q];
  assign hold_expired  = (hold_cnt_q == HOLD_LAST);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= 2'd3;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_req) state_d = GRANT;
      end
      GRANT: begin
        if (owner_release || hold_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d      = 4'b0001 << winner;
          sel_d      = winner;
          last_d     = winner;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (owner_release) begin
          // A normal release takes priority, even when the hold limit is reached in the same cycle.
          gnt_d = '0;
        end else if (hold_expired) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter with MAX_HOLD = 4. The directed steps come first and
// random traffic follows. Each cycle is compared against a transaction-level
// model of owner and hold time.
module tb_mux4_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic   clk;
  logic   rst_n;
  state_t state_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- reference model ----------------
  // The owner is -1 when idle. held counts the cycles the current owner has seen gnt high.
  int   m_owner;
  int   m_last;
  int   m_held;
  int   m_sel;
  logic m_to;

  // Scoreboard entry: {state==GRANT, gnt, sel, busy, timeout}
  logic [8:0] exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic model_edge(input logic [3:0] r, input logic d, input logic rn);
    bit found;
    if (!rn) begin
      m_owner = -1; m_last = 3; m_held = 0; m_sel = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && r[(m_last + k) % 4]) begin
            found   = 1'b1;
            m_owner = (m_last + k) % 4;
          end
        end
        if (found) begin
          m_last = m_owner; m_sel = m_owner; m_held = 1;
        end
      end else if (d || !r[m_owner]) begin
        m_owner = -1;
      end else if (m_held == MAX_HOLD) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic model_push();
    logic [3:0] g;
    logic       act;
    act = (m_owner >= 0);
    g   = act ? (4'b0001 << m_owner) : 4'b0000;
    exp_q.push_back({act, g, 2'(m_sel), act, m_to});
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic t);
    chk(tag, {1'b0, bus.gnt, bus.sel, bus.busy, bus.timeout}, {1'b0, g, s, b, t});
  endtask

  task automatic expect_gt(input string tag, input logic [3:0] g, input logic t);
    chk(tag, {4'b0, bus.gnt, bus.timeout}, {4'b0, g, t});
  endtask

  // ---------------- driver ----------------
  // Drives on the falling edge, lets the model see the same values at the
  // rising edge, and checks 1 time unit after that edge.
  task automatic cycle(input logic [3:0] r, input logic d, input logic rn);
    logic [8:0] obs;
    logic [8:0] exp;
    logic       inv_ok;
    @(negedge clk);
    bus.req  = r;
    bus.done = d;
    rst_n    = rn;
    @(posedge clk);
    model_edge(r, d, rn);
    model_push();
    #1;
    obs = {(state_o === GRANT), bus.gnt, bus.sel, bus.busy, bus.timeout};
    exp = exp_q.pop_front();
    chk("cycle_outputs", obs, exp);
    inv_ok = $onehot0(bus.gnt) && (bus.busy === (|bus.gnt)) &&
             (!bus.busy || (bus.gnt === (4'b0001 << bus.sel)));
    chk("invariant", {8'b0, inv_ok}, 9'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rot_order[4];
    logic [3:0] r;
    rot_order = '{1, 2, 3, 0};
    bus.req  = 4'b0;
    bus.done = 1'b0;
    rst_n    = 1'b0;

    // Reset: requests during reset are ignored.
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    expect_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // First grant goes to requester 0.
    cycle(4'b1111, 1'b0, 1'b1);
    expect_all("first_grant", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotation 0,1,2,3,0 with one idle cycle between owners.
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, 1'b1, 1'b1);
      expect_gt("rot_gap", 4'b0000, 1'b0);
      cycle(4'b1111, 1'b0, 1'b1);
      expect_gt("rot_grant", 4'b0001 << rot_order[i], 1'b0);
    end

    // Skip and wrap: make last = 2, then req 0011 wins 0.
    cycle(4'b0100, 1'b1, 1'b1);
    cycle(4'b0100, 1'b0, 1'b1);
    expect_gt("grant2", 4'b0100, 1'b0);
    cycle(4'b0011, 1'b1, 1'b1);
    cycle(4'b0011, 1'b0, 1'b1);
    expect_all("skip_wrap", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Forced release: requester 1 holds for exactly MAX_HOLD cycles.
    cycle(4'b0010, 1'b1, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle(4'b0010, 1'b0, 1'b1);
      expect_gt("hold", 4'b0010, 1'b0);
    end
    cycle(4'b0011, 1'b0, 1'b1);
    expect_all("forced_release", 4'b0000, 2'd1, 1'b0, 1'b1);
    cycle(4'b0011, 1'b0, 1'b1);
    expect_all("after_forced", 4'b0001, 2'd0, 1'b1, 1'b0);

    // done in the same cycle that the hold limit is reached gives a normal release.
    for (int i = 1; i < MAX_HOLD; i++) cycle(4'b0001, 1'b0, 1'b1);
    expect_gt("hold_full", 4'b0001, 1'b0);
    cycle(4'b0001, 1'b1, 1'b1);
    expect_gt("done_at_limit", 4'b0000, 1'b0);

    // Request drop mid-grant.
    cycle(4'b0010, 1'b0, 1'b1);
    expect_gt("grant1", 4'b0010, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    expect_gt("req_drop", 4'b0000, 1'b0);

    // Reset while requester 2 owns the mux.
    cycle(4'b0100, 1'b0, 1'b1);
    expect_gt("grant2_b", 4'b0100, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    expect_all("reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    cycle(4'b0101, 1'b0, 1'b1);
    expect_gt("after_reset", 4'b0001, 1'b0);

    // Random traffic with fast-changing requests.
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 63) != 0));
    end

    // Random traffic with sticky requests and rare done, so forced releases occur.
    r = 4'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) r = 4'($urandom_range(0, 15));
      cycle(r, ($urandom_range(0, 15) == 0), ($urandom_range(0, 127) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
